// File: rtl/parking_pkg.sv
// Shared parking definitions: park-number width, spot count and the exit-side
// token FSM state encoding.
package parking_pkg;

  localparam int PARK_W = 3;
  localparam int SPOTS  = 8;
  localparam int FAIL_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    GRANT = 3'd2,
    DENY  = 3'd3,
    LOCK  = 3'd4
  } token_state_e;

  // Consecutive-denial counter: holds at all-ones instead of wrapping.
  function automatic logic [FAIL_W-1:0] sat_inc(input logic [FAIL_W-1:0] v);
    return (v == {FAIL_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/exit_timer.sv
// Loadable down-counter shared by the gate-open and lockout intervals;
// done is high whenever the count sits at zero.
module exit_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/token_verification.sv
// Exit-side token check: decodes token ^ pattern into a park number, grants or
// denies the exit. Lockout after repeated denials is built when TOKEN_LOCKOUT_EN is defined.
module token_verification
  import parking_pkg::*;
#(
  parameter int GATE_CYCLES = 4,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              token_valid,
  output logic              token_ready,
  input  logic [PARK_W-1:0] token,
  input  logic [PARK_W-1:0] pattern,
  input  logic [SPOTS-1:0]  occupied,
  output logic              gate_open,
  output logic              exit_deny,
  output logic              release_valid,
  output logic [PARK_W-1:0] release_spot,
  output logic [FAIL_W-1:0] fail_count,
  output logic              locked
);

`ifdef TOKEN_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  localparam int MAX_CYC = (GATE_CYCLES > LOCK_CYCLES) ? GATE_CYCLES : LOCK_CYCLES;
  localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  token_state_e        state, state_n;
  logic [PARK_W-1:0]   park_q;
  logic                timer_load;
  logic [TIMER_W-1:0]  timer_load_value;
  logic                timer_en;
  logic                timer_done;
  logic                accept;
  logic                grant_entry;
  logic                deny_entry;
  logic                lock_exit;

  // Valid/ready: a token transfers on a rising edge where token_valid and
  // token_ready are both high; ready depends on state only, never on valid.
  assign token_ready = (state == IDLE);
  assign accept      = token_valid && token_ready;

  exit_timer #(.W(TIMER_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .load_value (timer_load_value),
    .en         (timer_en),
    .done       (timer_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n          = state;
    timer_load       = 1'b0;
    timer_load_value = '0;
    timer_en         = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_n = CHECK;
      end
      CHECK: begin
        if (occupied[park_q]) begin
          state_n          = GRANT;
          timer_load       = 1'b1;
          timer_load_value = TIMER_W'(GATE_CYCLES - 1);
        end else begin
          state_n = DENY;
        end
      end
      GRANT: begin
        if (timer_done) state_n = IDLE;
        else            timer_en = 1'b1;
      end
      DENY: begin
        // fail_count already holds the incremented value while in DENY.
        if (LOCK_EN && (fail_count == FAIL_W'(MAX_FAILS))) begin
          state_n          = LOCK;
          timer_load       = 1'b1;
          timer_load_value = TIMER_W'(LOCK_CYCLES - 1);
        end else begin
          state_n = IDLE;
        end
      end
      LOCK: begin
        if (timer_done) state_n = IDLE;
        else            timer_en = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  assign grant_entry = (state == CHECK) && (state_n == GRANT);
  assign deny_entry  = (state == CHECK) && (state_n == DENY);
  assign lock_exit   = (state == LOCK)  && (state_n == IDLE);

  // Outputs are flops loaded from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      park_q        <= '0;
      gate_open     <= 1'b0;
      exit_deny     <= 1'b0;
      release_valid <= 1'b0;
      release_spot  <= '0;
      fail_count    <= '0;
    end else begin
      if (accept) park_q <= token ^ pattern;
      gate_open     <= (state_n == GRANT);
      exit_deny     <= (state_n == DENY);
      release_valid <= grant_entry;
      if (grant_entry) release_spot <= park_q;
      if (grant_entry || lock_exit) begin
        fail_count <= '0;
      end else if (deny_entry) begin
        fail_count <= sat_inc(fail_count);
      end
    end
  end

`ifdef TOKEN_LOCKOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked <= 1'b0;
    end else begin
      locked <= (state_n == LOCK);
    end
  end
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_token_verification.sv
// Directed bench for token_verification: vector table of single exits plus
// hand-written lockout, recovery and reset-during-grant sequences.
module tb_token_verification;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       token_valid;
  logic       token_ready;
  logic [2:0] token;
  logic [2:0] pattern;
  logic [7:0] occupied;
  logic       gate_open;
  logic       exit_deny;
  logic       release_valid;
  logic [2:0] release_spot;
  logic [3:0] fail_count;
  logic       locked;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] pat;
    logic [2:0] tok;
    logic [7:0] occ;
    logic       grant;
    logic [2:0] spot;
    logic [3:0] fail;
  } vec_t;

  vec_t vecs [9];

  token_verification dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .token_valid   (token_valid),
    .token_ready   (token_ready),
    .token         (token),
    .pattern       (pattern),
    .occupied      (occupied),
    .gate_open     (gate_open),
    .exit_deny     (exit_deny),
    .release_valid (release_valid),
    .release_spot  (release_spot),
    .fail_count    (fail_count),
    .locked        (locked)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One exit attempt; samples #1 after each rising edge.
  task automatic run_txn(input logic [2:0] pat, input logic [2:0] tok, input logic [7:0] occ,
                         input logic exp_grant, input logic [2:0] exp_spot,
                         input logic [3:0] exp_fail, input logic exp_lock);
    int cnt;
    int rel;
    cnt = 0;
    while (!token_ready && cnt < 200) begin
      step();
      cnt++;
    end
    check("ready_before_accept", token_ready, 1);
    token_valid = 1'b1;
    token       = tok;
    pattern     = pat;
    occupied    = occ;
    step();                       // accept edge N
    token_valid = 1'b0;
    token       = ~tok;
    pattern     = ~pat;           // must not disturb the recorded park number
    check("ready_in_check", token_ready, 0);
    check("no_gate_in_check", gate_open, 0);
    step();                       // decision edge N+1
    occupied = ~occ;              // late occupancy change must not matter
    check("gate_first", gate_open, exp_grant);
    check("release_first", release_valid, exp_grant);
    check("deny_first", exit_deny, !exp_grant);
    check("fail_count", fail_count, exp_fail);
    if (exp_grant) begin
      check("release_spot", release_spot, exp_spot);
      cnt = 0;
      rel = 0;
      while (gate_open && cnt < 50) begin
        cnt++;
        step();
        if (release_valid) rel++;
      end
      check("gate_cycles", cnt, 4);
      check("extra_release", rel, 0);
      check("ready_after_grant", token_ready, 1);
    end else begin
      step();
      check("deny_pulse_end", exit_deny, 0);
      check("ready_after_deny", token_ready, !exp_lock);
      check("locked_after_deny", locked, exp_lock);
    end
  endtask

  initial begin
    int cnt;
    int rel;
    int gcnt;
    vecs[0] = '{3'b101, 3'b011, 8'b0100_0000, 1'b1, 3'd6, 4'd0};
    vecs[1] = '{3'b101, 3'b011, 8'b0000_0000, 1'b0, 3'd0, 4'd1};
    vecs[2] = '{3'b000, 3'b000, 8'b0000_0001, 1'b1, 3'd0, 4'd0};
    vecs[3] = '{3'b111, 3'b000, 8'b1000_0000, 1'b1, 3'd7, 4'd0};
    vecs[4] = '{3'b010, 3'b011, 8'b1111_1101, 1'b0, 3'd0, 4'd1};
    vecs[5] = '{3'b010, 3'b001, 8'b1111_1101, 1'b1, 3'd3, 4'd0};
    vecs[6] = '{3'b110, 3'b100, 8'b0000_0100, 1'b1, 3'd2, 4'd0};
    vecs[7] = '{3'b001, 3'b101, 8'b1110_1111, 1'b0, 3'd0, 4'd1};
    vecs[8] = '{3'b001, 3'b100, 8'b0010_0000, 1'b1, 3'd5, 4'd0};

    rst_n       = 1'b0;
    token_valid = 1'b0;
    token       = '0;
    pattern     = '0;
    occupied    = '0;
    #12;
    check("rst_ready", token_ready, 1);
    check("rst_gate", gate_open, 0);
    check("rst_deny", exit_deny, 0);
    check("rst_release", release_valid, 0);
    check("rst_spot", release_spot, 0);
    check("rst_fail", fail_count, 0);
    check("rst_locked", locked, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i].pat, vecs[i].tok, vecs[i].occ, vecs[i].grant,
              vecs[i].spot, vecs[i].fail, 1'b0);
    end

    // Three consecutive denials.
    run_txn(3'b101, 3'b011, 8'h00, 1'b0, 3'd0, 4'd1, 1'b0);
    run_txn(3'b101, 3'b011, 8'h00, 1'b0, 3'd0, 4'd2, 1'b0);
`ifdef TOKEN_LOCKOUT_EN
    run_txn(3'b101, 3'b011, 8'h00, 1'b0, 3'd0, 4'd3, 1'b1);
    cnt = 0;
    while (locked && cnt < 100) begin
      cnt++;
      check("ready_while_locked", token_ready, 0);
      step();
    end
    check("lock_cycles", cnt, 16);
    check("fail_after_lock", fail_count, 0);
    check("ready_after_lock", token_ready, 1);
`else
    run_txn(3'b101, 3'b011, 8'h00, 1'b0, 3'd0, 4'd3, 1'b0);
    check("no_lock_fail", fail_count, 3);
    for (int k = 4; k <= 16; k++) begin
      run_txn(3'b101, 3'b011, 8'h00, 1'b0, 3'd0, (k > 15) ? 4'd15 : 4'(k), 1'b0);
    end
`endif
    run_txn(3'b000, 3'b010, 8'b0000_0100, 1'b1, 3'd2, 4'd0, 1'b0);

    // Recovery: two denials, then a valid exit clears the count.
    run_txn(3'b011, 3'b011, 8'b1111_1110, 1'b0, 3'd0, 4'd1, 1'b0);
    run_txn(3'b011, 3'b010, 8'b1111_1101, 1'b0, 3'd0, 4'd2, 1'b0);
    run_txn(3'b101, 3'b011, 8'b0100_0000, 1'b1, 3'd6, 4'd0, 1'b0);

    // Reset asserted in the second gate cycle.
    run_txn(3'b101, 3'b011, 8'h00, 1'b0, 3'd0, 4'd1, 1'b0);
    token_valid = 1'b1;
    token       = 3'b011;
    pattern     = 3'b101;
    occupied    = 8'b0100_0000;
    step();
    token_valid = 1'b0;
    step();
    check("mid_gate_1", gate_open, 1);
    step();
    check("mid_gate_2", gate_open, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_gate", gate_open, 0);
    check("mid_rst_ready", token_ready, 1);
    check("mid_rst_release", release_valid, 0);
    check("mid_rst_fail", fail_count, 0);
    check("mid_rst_spot", release_spot, 0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    rel  = 0;
    gcnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (release_valid) rel++;
      if (gate_open) gcnt++;
    end
    check("post_rst_release", rel, 0);
    check("post_rst_gate", gcnt, 0);
    check("post_rst_ready", token_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
